// File: rtl/cla16_bist_pkg.sv
// ============================================================================
// Module   : cla16_bist_pkg
// Brief    : Shared types and constants for the cla16_bist self-test stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cla16_bist_pkg;

  localparam int          OP_W      = 16;
  localparam logic [31:0] LFSR_MASK = 32'h80200003;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    SETTLE = ST_SETTLE,
    CHECK  = ST_CHECK,
    DONE   = ST_DONE
  } state_e;

  // Right-shifting Galois step: feedback taps are XORed in when bit 0 falls out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla16_bist_if.sv
// ============================================================================
// Module   : cla16_bist_if
// Brief    : Adder-facing and status signals of the cla16_bist self-test stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cla16_bist_if #(
  parameter int CNT_W = 5
);
  import cla16_bist_pkg::*;

  logic              start;
  logic [OP_W-1:0]   add_sum;
  logic              add_cout;
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic              op_cin;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  pass_cnt;
  logic [CNT_W-1:0]  fail_cnt;
  logic              fail_any;
  logic [OP_W-1:0]   fail_a;
  logic [OP_W-1:0]   fail_b;
  logic              fail_cin;
  logic [OP_W:0]     fail_got;

  modport master (
    input  start, add_sum, add_cout,
    output op_a, op_b, op_cin, busy, done, pass_cnt, fail_cnt, fail_any,
           fail_a, fail_b, fail_cin, fail_got
  );

  modport slave (
    output start, add_sum, add_cout,
    input  op_a, op_b, op_cin, busy, done, pass_cnt, fail_cnt, fail_any,
           fail_a, fail_b, fail_cin, fail_got
  );

endinterface

`default_nettype wire

// File: rtl/cla16_bist_lfsr32.sv
// ============================================================================
// Module   : lfsr32
// Brief    : 32-bit Galois LFSR with seed load and single-step enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr32
  import cla16_bist_pkg::*;
#(
  parameter logic [31:0] INIT = 32'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (step) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

`default_nettype wire

// File: rtl/cla16_bist.sv
// ============================================================================
// Module   : cla16_bist
// Brief    : LFSR-driven BIST for a 16-bit adder; counts matching vectors.
//            Optional first-failure capture enabled by FAIL_CAPTURE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla16_bist
  import cla16_bist_pkg::*;
#(
  parameter int          NUM_TESTS  = 20,
  parameter int          SETTLE_CYC = 8,
  parameter logic [31:0] SEED       = 32'hACE1,
  parameter int          CNT_W      = $clog2(NUM_TESTS + 1)
) (
  input  logic         clk,
  input  logic         rst,
  cla16_bist_if.master bus
);

  localparam logic [31:0] SEED_FIX = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam int          IDX_W    = (NUM_TESTS  > 1) ? $clog2(NUM_TESTS)  : 1;
  localparam int          SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_a_q, op_a_d;
  logic [OP_W-1:0]   op_b_q, op_b_d;
  logic              op_cin_q, op_cin_d;
  logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic              lfsr_step;
  logic [31:0]       lfsr_state;
  logic [OP_W:0]     exp_sum;
  logic [OP_W:0]     got_sum;
  logic              match;

  lfsr32 #(
    .INIT (SEED_FIX)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (1'b0),
    .seed  (SEED_FIX),
    .step  (lfsr_step),
    .state (lfsr_state)
  );

  assign exp_sum = {1'b0, op_a_q} + {1'b0, op_b_q} + {{OP_W{1'b0}}, op_cin_q};
  assign got_sum = {bus.add_cout, bus.add_sum};
  assign match   = (got_sum == exp_sum);

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_cin_d   = op_cin_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    lfsr_step  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        // A new run continues the LFSR sequence; only reset reseeds it.
        if (bus.start) begin
          state_d    = LOAD;
          pass_cnt_d = '0;
          fail_cnt_d = '0;
          idx_d      = '0;
        end
      end
      LOAD: begin
        op_a_d    = lfsr_state[15:0];
        op_b_d    = lfsr_state[31:16];
        op_cin_d  = lfsr_state[0] ^ lfsr_state[16];
        lfsr_step = 1'b1;
        settle_d  = SET_W'(SETTLE_CYC - 1);
        state_d   = SETTLE;
      end
      SETTLE: begin
        if (settle_q == '0) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      CHECK: begin
        if (match) begin
          pass_cnt_d = pass_cnt_q + CNT_W'(1);
        end else begin
          fail_cnt_d = fail_cnt_q + CNT_W'(1);
        end
        if (idx_q == IDX_W'(NUM_TESTS - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_cin_q   <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      idx_q      <= '0;
      settle_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_cin_q   <= op_cin_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
    end
  end

  assign bus.op_a     = op_a_q;
  assign bus.op_b     = op_b_q;
  assign bus.op_cin   = op_cin_q;
  assign bus.busy     = (state_q == LOAD) || (state_q == SETTLE) || (state_q == CHECK);
  assign bus.done     = (state_q == DONE);
  assign bus.pass_cnt = pass_cnt_q;
  assign bus.fail_cnt = fail_cnt_q;
  assign bus.fail_any = (fail_cnt_q != '0);

`ifdef FAIL_CAPTURE_EN
  logic [OP_W-1:0] fail_a_q, fail_a_d;
  logic [OP_W-1:0] fail_b_q, fail_b_d;
  logic            fail_cin_q, fail_cin_d;
  logic [OP_W:0]   fail_got_q, fail_got_d;

  // Only the first mismatch of a run is kept: fail_cnt is still zero for it.
  always_comb begin
    fail_a_d   = fail_a_q;
    fail_b_d   = fail_b_q;
    fail_cin_d = fail_cin_q;
    fail_got_d = fail_got_q;
    if (((state_q == IDLE) || (state_q == DONE)) && bus.start) begin
      fail_a_d   = '0;
      fail_b_d   = '0;
      fail_cin_d = 1'b0;
      fail_got_d = '0;
    end else if ((state_q == CHECK) && !match && (fail_cnt_q == '0)) begin
      fail_a_d   = op_a_q;
      fail_b_d   = op_b_q;
      fail_cin_d = op_cin_q;
      fail_got_d = got_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      fail_cin_q <= 1'b0;
      fail_got_q <= '0;
    end else begin
      fail_a_q   <= fail_a_d;
      fail_b_q   <= fail_b_d;
      fail_cin_q <= fail_cin_d;
      fail_got_q <= fail_got_d;
    end
  end

  assign bus.fail_a   = fail_a_q;
  assign bus.fail_b   = fail_b_q;
  assign bus.fail_cin = fail_cin_q;
  assign bus.fail_got = fail_got_q;
`else
  assign bus.fail_a   = '0;
  assign bus.fail_b   = '0;
  assign bus.fail_cin = 1'b0;
  assign bus.fail_got = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cla16_bist.sv
// ============================================================================
// Module   : tb_cla16_bist
// Brief    : Self-checking bench for cla16_bist with a behavioural adder stub.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cla16_bist;
  import cla16_bist_pkg::*;

  localparam int          NUM_TESTS  = 20;
  localparam int          SETTLE_CYC = 8;
  localparam logic [31:0] SEED       = 32'hACE1;
  localparam int          CNT_W      = 5;
  localparam int          DONE_EDGE  = NUM_TESTS * (SETTLE_CYC + 2) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla16_bist_if #(.CNT_W(CNT_W)) bus();

  cla16_bist #(
    .NUM_TESTS  (NUM_TESTS),
    .SETTLE_CYC (SETTLE_CYC),
    .SEED       (SEED),
    .CNT_W      (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Adder under test: 0 = correct, 1 = carry-out stuck 0, 2 = inverted result.
  int          mode;
  logic [16:0] true_sum;
  always_comb begin
    true_sum = {1'b0, bus.op_a} + {1'b0, bus.op_b} + {16'b0, bus.op_cin};
    case (mode)
      1:       {bus.add_cout, bus.add_sum} = {1'b0, true_sum[15:0]};
      2:       {bus.add_cout, bus.add_sum} = ~true_sum;
      default: {bus.add_cout, bus.add_sum} = true_sum;
    endcase
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
  } vec_t;

  // cmp: 0 = no cross-run check, 1 = first op_a must differ from run 1, 2 = must equal it
  typedef struct {
    int mode;
    int stray_edge;
    int cmp;
  } run_t;

  vec_t        sb[$];
  run_t        runs[3];
  logic [31:0] m_lfsr;
  logic [15:0] run1_first_a;

  task automatic do_run(input run_t r, input bit record_first);
    int          exp_pass = 0;
    int          exp_fail = 0;
    int          n;
    bit          have_cap = 0;
    logic [49:0] cap_exp = '0;
    logic [15:0] dut_first_a = '0;
    logic [16:0] e;
    vec_t        v;

    for (int k = 0; k < NUM_TESTS; k++) begin
      v.a   = m_lfsr[15:0];
      v.b   = m_lfsr[31:16];
      v.cin = m_lfsr[0] ^ m_lfsr[16];
      m_lfsr = m_step(m_lfsr);
      sb.push_back(v);
      e = {1'b0, v.a} + {1'b0, v.b} + {16'b0, v.cin};
      if (r.mode == 0 || (r.mode == 1 && !e[16])) begin
        exp_pass++;
      end else begin
        exp_fail++;
`ifdef FAIL_CAPTURE_EN
        if (!have_cap) begin
          have_cap = 1;
          cap_exp  = {v.a, v.b, v.cin, (r.mode == 2) ? ~e : {1'b0, e[15:0]}};
        end
`endif
      end
    end

    @(negedge clk);
    mode      = r.mode;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 1;
    chk("start_clears", {bus.busy, bus.done, bus.pass_cnt, bus.fail_cnt}, {1'b1, 1'b0, 10'd0});

    while (!bus.done && n < DONE_EDGE + 40) begin
      @(negedge clk);
      if (n + 1 == r.stray_edge) bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      n++;
      chk("busy_done_excl", {63'd0, bus.busy & bus.done}, 64'd0);
      if (n >= 3 && (n - 3) % (SETTLE_CYC + 2) == 0 && !bus.done) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          v = sb.pop_front();
          chk("op_vec", {bus.op_a, bus.op_b, bus.op_cin}, {v.a, v.b, v.cin});
          if (n == 3) dut_first_a = bus.op_a;
        end
      end
    end

    chk("done_edge", n, DONE_EDGE);
    chk("sb_empty", sb.size(), 0);
    chk("pass_cnt", bus.pass_cnt, exp_pass);
    chk("fail_cnt", bus.fail_cnt, exp_fail);
    chk("fail_any", bus.fail_any, exp_fail != 0);
    chk("fail_capture", {bus.fail_a, bus.fail_b, bus.fail_cin, bus.fail_got}, cap_exp);
    if (record_first) run1_first_a = dut_first_a;
    if (r.cmp == 1) chk("new_vectors", dut_first_a != run1_first_a, 1);
    if (r.cmp == 2) chk("replay_vectors", dut_first_a, run1_first_a);
    sb.delete();
  endtask

  initial begin
    runs[0] = '{mode: 0, stray_edge: 50, cmp: 0};
    runs[1] = '{mode: 1, stray_edge: 0,  cmp: 1};
    runs[2] = '{mode: 2, stray_edge: 0,  cmp: 2};

    mode      = 0;
    bus.start = 1'b0;
    rst       = 1'b1;
    m_lfsr    = SEED;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {bus.op_a, bus.op_b, bus.op_cin, bus.busy, bus.done, bus.pass_cnt, bus.fail_cnt, bus.fail_any},
        64'd0);
    chk("reset_capture", {bus.fail_a, bus.fail_b, bus.fail_cin, bus.fail_got}, 64'd0);
    rst = 1'b0;

    do_run(runs[0], 1'b1);
    do_run(runs[1], 1'b0);

    // Abort a run in SETTLE of vector 4 and confirm the reset takes effect before any edge.
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (36) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_outputs",
        {bus.op_a, bus.op_b, bus.op_cin, bus.busy, bus.done, bus.pass_cnt, bus.fail_cnt, bus.fail_any},
        64'd0);
    @(negedge clk);
    rst    = 1'b0;
    m_lfsr = SEED;
    @(negedge clk);
    chk("idle_after_abort", {bus.busy, bus.done}, 2'b00);

    do_run(runs[2], 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
